branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline; replaces static predict-not-taken fetch.
- Direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters.
- Fetch stage performs a combinational lookup on PCF.
- Execute stage writes back the resolved outcome; the block reports misprediction and the correct redirect PC, so the hazard unit flushes only on mispredict.

Parameters:
- DATA_WIDTH, 32: PC/target width.
- ENTRIES, 16: BTB depth; power of two, >=2.
- IDX_BITS, $clog2(ENTRIES): index width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low.
- pc_f  in  DATA_WIDTH  fetch PC.
- pred_taken_f  out  1  predict taken for pc_f.
- pred_target_f  out  DATA_WIDTH  predicted next PC (target if taken, else pc_f+4).
- upd_valid_e  in  1  execute stage holds a resolved branch or jump this cycle.
- upd_pc_e  in  DATA_WIDTH  PC of the resolved instruction.
- upd_is_jump_e  in  1  unconditional jump (jal/jalr).
- upd_taken_e  in  1  actual outcome.
- upd_target_e  in  DATA_WIDTH  actual target.
- upd_pred_taken_e  in  1  prediction made at fetch, piped through.
- upd_pred_target_e  in  DATA_WIDTH  predicted next PC, piped through.
- mispredict_e  out  1  redirect required.
- redirect_pc_e  out  DATA_WIDTH  correct next PC.
- flush_all  in  1  synchronous invalidate of all entries (fence.i).
- stat_branches  out  32  resolved count (BP_STATS_EN).
- stat_mispredicts  out  32  mispredict count (BP_STATS_EN).

Behaviour:
- Entry fields: valid, tag, target, ctr[1:0], is_jump.
  - index = pc[IDX_BITS+1:2]
  - tag = pc[DATA_WIDTH-1:IDX_BITS+2]
- Lookup (combinational, 0 latency):
  - hit = valid & tag match.
  - pred_taken_f = hit & (is_jump | ctr[1]).
  - pred_target_f = pred_taken_f ? target : pc_f+4 (modulo 2^DATA_WIDTH).
- Mispredict (combinational, gated by upd_valid_e, 0 when upd_valid_e=0):
  - actual_next = upd_taken_e ? upd_target_e : upd_pc_e+4.
  - mispredict_e = (upd_pred_taken_e != upd_taken_e) | (upd_pred_target_e != actual_next).
  - redirect_pc_e = actual_next.
- Update (posedge, when upd_valid_e):
  - Hit, taken: ctr saturating increment (max 2'b11); target <= upd_target_e; is_jump <= upd_is_jump_e.
  - Hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate/overwrite entry. valid=1, tag, target, is_jump, ctr=2'b10 (weakly taken).
  - Miss, not taken: no change.
- Same-cycle lookup and update on the same index: lookup returns pre-update state; the new state is visible the next cycle.
- flush_all:
  - Clears all valid bits next edge; counters are left unchanged.
  - If asserted together with upd_valid_e, flush wins: no allocation or update.
  - Stats are unaffected.
- Reset (rst=0, async):
  - Every entry has valid=0, ctr=2'b01, tag/target=0.
  - Therefore pred_taken_f=0 and pred_target_f=pc_f+4.
  - mispredict_e follows its combinational inputs.
  - Stats = 0.
- Reset deasserted mid-operation: the table is empty and behaves as cold start.

Optional Feature:
- BP_STATS_EN defined:
  - stat_branches increments on every upd_valid_e.
  - stat_mispredicts increments when upd_valid_e & mispredict_e.
  - Both saturate at 32'hFFFFFFFF and clear only on reset.
- BP_STATS_EN undefined: no counter registers are built; both stat outputs are tied to 0.

Test Plan:
- Cold start after reset, pc_f=0x100 -> pred_taken_f=0, pred_target_f=0x104; stats 0.
- Update pc 0x100 taken, target 0x80, pred_taken=0 -> mispredict_e=1, redirect_pc_e=0x80. Next cycle lookup 0x100 -> taken, target 0x80; ctr=2'b10.
- Same branch not-taken twice -> ctr 10->01->00; lookup gives pred_taken_f=0, pred_target_f=0x104. Third not-taken keeps ctr=00 (saturation).
- Aliasing, ENTRIES=16:
  - Taken branch at 0x100 allocated, then taken branch at 0x140 (same index, different tag) -> 0x140 hits, 0x100 misses.
  - Jump allocated with is_jump=1 -> always predicts taken regardless of ctr.
- Predicted taken to 0x80, actual taken to 0x90 (jalr) -> mispredict_e=1, redirect_pc_e=0x90, entry target becomes 0x90.
- flush_all with simultaneous update -> all lookups miss next cycle; with BP_STATS_EN, stat_branches still increments by 1.

Source files
------------

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters.
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor #(
    parameter int DATA_WIDTH = 32,
    parameter int ENTRIES    = 16,
    parameter int IDX_BITS   = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_f,
    output logic                  pred_taken_f,
    output logic [DATA_WIDTH-1:0] pred_target_f,
    input  logic                  upd_valid_e,
    input  logic [DATA_WIDTH-1:0] upd_pc_e,
    input  logic                  upd_is_jump_e,
    input  logic                  upd_taken_e,
    input  logic [DATA_WIDTH-1:0] upd_target_e,
    input  logic                  upd_pred_taken_e,
    input  logic [DATA_WIDTH-1:0] upd_pred_target_e,
    output logic                  mispredict_e,
    output logic [DATA_WIDTH-1:0] redirect_pc_e,
    input  logic                  flush_all,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
);

    localparam int TagBits = DATA_WIDTH - IDX_BITS - 2;

    logic                  validQ  [ENTRIES];
    logic [TagBits-1:0]    tagQ    [ENTRIES];
    logic [DATA_WIDTH-1:0] targetQ [ENTRIES];
    logic [1:0]            ctrQ    [ENTRIES];
    logic                  jumpQ   [ENTRIES];

    logic [IDX_BITS-1:0]   fetchIdx;
    logic [TagBits-1:0]    fetchTag;
    logic                  fetchHit;
    logic [IDX_BITS-1:0]   updIdx;
    logic [TagBits-1:0]    updTag;
    logic                  updHit;
    logic [DATA_WIDTH-1:0] actualNext;

    // Word-alignment bits never take part in indexing or tagging.
    logic unusedPcBits;
    assign unusedPcBits = ^{pc_f[1:0], upd_pc_e[1:0]};

    assign fetchIdx = pc_f[IDX_BITS+1:2];
    assign fetchTag = pc_f[DATA_WIDTH-1:IDX_BITS+2];
    assign fetchHit = validQ[fetchIdx] && (tagQ[fetchIdx] == fetchTag);

    assign updIdx = upd_pc_e[IDX_BITS+1:2];
    assign updTag = upd_pc_e[DATA_WIDTH-1:IDX_BITS+2];
    assign updHit = validQ[updIdx] && (tagQ[updIdx] == updTag);

    always_comb begin
        pred_taken_f  = fetchHit && (jumpQ[fetchIdx] || ctrQ[fetchIdx][1]);
        pred_target_f = pred_taken_f ? targetQ[fetchIdx] : pc_f + DATA_WIDTH'(4);
    end

    always_comb begin
        actualNext    = upd_taken_e ? upd_target_e : upd_pc_e + DATA_WIDTH'(4);
        redirect_pc_e = actualNext;
        mispredict_e  = upd_valid_e &&
                        ((upd_pred_taken_e != upd_taken_e) || (upd_pred_target_e != actualNext));
    end

    // Lookup reads the pre-edge table, so same-cycle updates appear one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i]  <= 1'b0;
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                ctrQ[i]    <= 2'b01;
                jumpQ[i]   <= 1'b0;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i] <= 1'b0;
            end
        end else if (upd_valid_e) begin
            if (updHit) begin
                if (upd_taken_e) begin
                    ctrQ[updIdx]    <= (ctrQ[updIdx] == 2'b11) ? 2'b11 : ctrQ[updIdx] + 2'd1;
                    targetQ[updIdx] <= upd_target_e;
                    jumpQ[updIdx]   <= upd_is_jump_e;
                end else begin
                    ctrQ[updIdx] <= (ctrQ[updIdx] == 2'b00) ? 2'b00 : ctrQ[updIdx] - 2'd1;
                end
            end else if (upd_taken_e) begin
                validQ[updIdx]  <= 1'b1;
                tagQ[updIdx]    <= updTag;
                targetQ[updIdx] <= upd_target_e;
                jumpQ[updIdx]   <= upd_is_jump_e;
                ctrQ[updIdx]    <= 2'b10;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branchCntQ;
    logic [31:0] mispCntQ;

    // Counts continue through flush_all; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branchCntQ <= '0;
            mispCntQ   <= '0;
        end else if (upd_valid_e) begin
            if (branchCntQ != 32'hFFFF_FFFF) begin
                branchCntQ <= branchCntQ + 32'd1;
            end
            if (mispredict_e && (mispCntQ != 32'hFFFF_FFFF)) begin
                mispCntQ <= mispCntQ + 32'd1;
            end
        end
    end

    assign stat_branches    = branchCntQ;
    assign stat_mispredicts = mispCntQ;
`else
    assign stat_branches    = 32'd0;
    assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed plan steps then random traffic against a BTB model.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        upd_valid_e;
    logic [31:0] upd_pc_e;
    logic        upd_is_jump_e;
    logic        upd_taken_e;
    logic [31:0] upd_target_e;
    logic        upd_pred_taken_e;
    logic [31:0] upd_pred_target_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic        flush_all;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    branch_predictor #(
        .DATA_WIDTH (32),
        .ENTRIES    (16)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_f              (pc_f),
        .pred_taken_f      (pred_taken_f),
        .pred_target_f     (pred_target_f),
        .upd_valid_e       (upd_valid_e),
        .upd_pc_e          (upd_pc_e),
        .upd_is_jump_e     (upd_is_jump_e),
        .upd_taken_e       (upd_taken_e),
        .upd_target_e      (upd_target_e),
        .upd_pred_taken_e  (upd_pred_taken_e),
        .upd_pred_target_e (upd_pred_target_e),
        .mispredict_e      (mispredict_e),
        .redirect_pc_e     (redirect_pc_e),
        .flush_all         (flush_all),
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int testCount = 0;
    int failCount = 0;

    // Reference model: one record per BTB slot, counter kept as an integer 0..3.
    bit          mValid  [16];
    int unsigned mTag    [16];
    logic [31:0] mTarget [16];
    int          mCtr    [16];
    bit          mJump   [16];
    longint      mBranches;
    longint      mMisp;

    function automatic int slotOf(logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic bit modelHit(logic [31:0] pc);
        int s = slotOf(pc);
        return mValid[s] && (mTag[s] == 32'(pc / 64));
    endfunction

    function automatic bit modelTaken(logic [31:0] pc);
        int s = slotOf(pc);
        return modelHit(pc) && (mJump[s] || mCtr[s] >= 2);
    endfunction

    function automatic logic [31:0] modelTarget(logic [31:0] pc);
        if (modelTaken(pc)) return mTarget[slotOf(pc)];
        return pc + 32'd4;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 0; mTag[i] = 0; mTarget[i] = '0; mCtr[i] = 1; mJump[i] = 0;
        end
        mBranches = 0;
        mMisp = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expStat(longint v);
`ifdef BP_STATS_EN
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
        return (v >= 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Called at a negedge: drive, check combinational outputs, clock, advance the model.
    task automatic doCycle(input logic [31:0] pcF, input bit v, input logic [31:0] uPc,
                           input bit isJ, input bit tk, input logic [31:0] tgt,
                           input bit pTk, input logic [31:0] pTgt, input bit fl);
        logic [31:0] actual;
        bit          expMisp;
        int          s;
        pc_f = pcF; upd_valid_e = v; upd_pc_e = uPc; upd_is_jump_e = isJ;
        upd_taken_e = tk; upd_target_e = tgt; upd_pred_taken_e = pTk;
        upd_pred_target_e = pTgt; flush_all = fl;
        #1;
        actual  = tk ? tgt : uPc + 32'd4;
        expMisp = v && ((pTk != tk) || (pTgt != actual));
        chk("pred_taken", {31'd0, pred_taken_f}, {31'd0, modelTaken(pcF)});
        chk("pred_target", pred_target_f, modelTarget(pcF));
        chk("mispredict", {31'd0, mispredict_e}, {31'd0, expMisp});
        chk("redirect", redirect_pc_e, actual);
        chk("stat_branches", stat_branches, expStat(mBranches));
        chk("stat_mispredicts", stat_mispredicts, expStat(mMisp));
        @(posedge clk);
        if (v) begin
            mBranches++;
            if (expMisp) mMisp++;
        end
        s = slotOf(uPc);
        if (fl) begin
            for (int i = 0; i < 16; i++) mValid[i] = 0;
        end else if (v) begin
            if (modelHit(uPc)) begin
                if (tk) begin
                    mCtr[s] = (mCtr[s] < 3) ? mCtr[s] + 1 : 3;
                    mTarget[s] = tgt;
                    mJump[s] = isJ;
                end else begin
                    mCtr[s] = (mCtr[s] > 0) ? mCtr[s] - 1 : 0;
                end
            end else if (tk) begin
                mValid[s] = 1; mTag[s] = 32'(uPc / 64); mTarget[s] = tgt;
                mJump[s] = isJ; mCtr[s] = 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic lookOnly(input logic [31:0] pcF);
        doCycle(pcF, 0, 32'h0, 0, 0, 32'h0, 0, 32'h4, 0);
    endtask

    initial begin
        logic [31:0] rPc, rTgt, rPtgt;
        bit          rTk, rPtk;
        rst = 1'b0;
        pc_f = 32'h100; upd_valid_e = 0; upd_pc_e = '0; upd_is_jump_e = 0; upd_taken_e = 0;
        upd_target_e = '0; upd_pred_taken_e = 0; upd_pred_target_e = '0; flush_all = 0;
        modelReset();
        #2;
        chk("cold_taken", {31'd0, pred_taken_f}, 32'd0);
        chk("cold_target", pred_target_f, 32'h104);
        chk("cold_stat_br", stat_branches, 32'd0);
        chk("cold_stat_mp", stat_mispredicts, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // First taken resolve allocates weakly-taken; same-cycle lookup still misses.
        doCycle(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 0);
        lookOnly(32'h100);
        chk("alloc_taken", {31'd0, pred_taken_f}, 32'd1);
        chk("alloc_target", pred_target_f, 32'h80);

        // Two not-taken: 10 -> 01 -> 00, then saturate, then one taken leaves it not-taken.
        doCycle(32'h100, 1, 32'h100, 0, 0, 32'h80, 1, 32'h80, 0);
        lookOnly(32'h100);
        chk("nt1_target", pred_target_f, 32'h104);
        doCycle(32'h100, 1, 32'h100, 0, 0, 32'h80, 0, 32'h104, 0);
        doCycle(32'h100, 1, 32'h100, 0, 0, 32'h80, 0, 32'h104, 0);
        doCycle(32'h100, 1, 32'h100, 0, 1, 32'h80, 0, 32'h104, 0);
        lookOnly(32'h100);
        chk("sat_low_taken", {31'd0, pred_taken_f}, 32'd0);

        // Aliasing on slot 0: 0x140 evicts 0x100.
        doCycle(32'h140, 1, 32'h140, 0, 1, 32'h40, 0, 32'h144, 0);
        lookOnly(32'h100);
        chk("alias_old_miss", {31'd0, pred_taken_f}, 32'd0);
        lookOnly(32'h140);
        chk("alias_new_hit", pred_target_f, 32'h40);

        // Jump stays predicted taken even after its counter drops.
        doCycle(32'h200, 1, 32'h200, 1, 1, 32'h300, 0, 32'h204, 0);
        doCycle(32'h200, 1, 32'h200, 1, 0, 32'h300, 1, 32'h300, 0);
        lookOnly(32'h200);
        chk("jump_taken", {31'd0, pred_taken_f}, 32'd1);

        // jalr target change: mispredict, redirect, and retarget.
        doCycle(32'h200, 1, 32'h200, 1, 1, 32'h90, 1, 32'h300, 0);
        lookOnly(32'h200);
        chk("jalr_retarget", pred_target_f, 32'h90);

        // Flush with simultaneous update: flush wins, stats still count.
        doCycle(32'h140, 1, 32'h180, 0, 1, 32'h10, 0, 32'h184, 1);
        lookOnly(32'h140);
        chk("flush_miss_a", {31'd0, pred_taken_f}, 32'd0);
        lookOnly(32'h180);
        chk("flush_miss_b", {31'd0, pred_taken_f}, 32'd0);

        // Random traffic over a few tags per slot to provoke aliasing.
        for (int n = 0; n < 400; n++) begin
            rPc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            rTgt = $urandom_range(0, 255) << 2;
            rTk  = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 1) == 1) begin
                rPtk = modelTaken(rPc); rPtgt = modelTarget(rPc);
            end else begin
                rPtk = $urandom_range(0, 1) == 1; rPtgt = $urandom_range(0, 255) << 2;
            end
            doCycle(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2),
                    $urandom_range(0, 3) != 0, rPc, $urandom_range(0, 5) == 0, rTk, rTgt,
                    rPtk, rPtgt, $urandom_range(0, 31) == 0);
            if (n == 200) begin
                // Mid-run reset returns to a cold table.
                rst = 1'b0;
                #1;
                modelReset();
                chk("midreset_target", pred_target_f, pc_f + 32'd4);
                chk("midreset_stat", stat_branches, 32'd0);
                #1;
                rst = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
